note_player: RTL

NOTE_PLAYER -- requirements
Module: note_player

---
 rtl/note_player.sv | 98 +++++++++
 1 files changed

// File: rtl/note_player.sv
// Note player: latches a note, counts its duration in beats and runs a
// phase accumulator whose MSB is a square wave at the note's pitch.
module note_player #(
  parameter int BEAT_BITS  = 6,
  parameter int PHASE_BITS = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  new_note,
  input  logic [5:0]            note,
  input  logic [BEAT_BITS-1:0]  duration,
  input  logic                  beat,
  input  logic                  sample_tick,
  input  logic [PHASE_BITS-1:0] step,
  output logic                  note_done,
  output logic                  busy,
  output logic [5:0]            current_note,
  output logic [PHASE_BITS-1:0] phase,
  output logic                  square
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [BEAT_BITS-1:0]  rem_q, rem_d;
  logic [5:0]            note_q, note_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      note_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      note_q  <= note_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    note_d  = note_q;
    phase_d = phase_q;
    if (new_note) begin
      note_d  = note;
      rem_d   = duration;
      phase_d = '0;
      if (duration == '0)
        state_d = DONE;
      else if (play)
        state_d = PLAYING;
      else
        state_d = PAUSED;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        PLAYING: begin
          if (sample_tick && note_q != '0)
            phase_d = phase_q + step;
          if (!play) begin
            state_d = PAUSED;
          end else if (beat) begin
            // A count of 0 cannot occur here; treat it like the last beat.
            if (rem_q <= BEAT_BITS'(1)) begin
              rem_d   = '0;
              state_d = DONE;
            end else begin
              rem_d = rem_q - BEAT_BITS'(1);
            end
          end
        end
        PAUSED: begin
          if (play)
            state_d = PLAYING;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign note_done    = (state_q == DONE);
  assign busy         = (state_q == PLAYING) || (state_q == PAUSED);
  assign current_note = note_q;
  assign phase        = phase_q;
  assign square       = phase_q[PHASE_BITS-1];

endmodule
